count_enable_gen: RTL and testbench



---
 rtl/count_enable_gen_if.sv | 12 +
 rtl/count_enable_gen.sv | 122 ++++++++++++
 tb/tb_count_enable_gen.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/count_enable_gen_if.sv
// Handshake bundle between the count-enable source and whoever drives the button/mode controls.
// The slave side is the enable generator; the master side supplies Btn/Mode/Pause.
interface count_enable_gen_if;
    logic Btn;
    logic Mode;
    logic Pause;
    logic En;
    logic Pressed;

    modport master (output Btn, output Mode, output Pause, input En, input Pressed);
    modport slave  (input Btn, input Mode, input Pause, output En, output Pressed);
endinterface

// File: rtl/count_enable_gen.sv
// Count-enable source for the up-counter: one En pulse per debounced button press
// in step mode, or one pulse every TICK_DIV clocks from a prescaler in auto mode.
module count_enable_gen #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TICK_DIV        = 10
) (
    input logic               Clk,
    input logic               Rst,
    count_enable_gen_if.slave bus
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam int DW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;
    logic [DW-1:0] div;
    logic          s1;
    logic          btn_s;
    logic          step_req;
    logic          en_next;
    logic          pressed_next;
    logic          en_q;
    logic          pressed_q;

    // Btn is asynchronous, so it passes through two flops before anything looks at it
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            s1    <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            s1    <= bus.Btn;
            btn_s <= s1;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= IDLE;
            cnt       <= '0;
            en_q      <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state     <= next_state;
            cnt       <= cnt_next;
            en_q      <= en_next;
            pressed_q <= pressed_next;
        end
    end

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (btn_s) begin
                    next_state = PRESS_WAIT;
                    cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    next_state = IDLE;
                end else if (cnt == CNT_LAST) begin
                    next_state = HELD;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    next_state = REL_WAIT;
                    cnt_next   = '0;
                end
            end
            REL_WAIT: begin
                if (btn_s) begin
                    next_state = HELD;
                end else if (cnt == CNT_LAST) begin
                    next_state = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            default: begin
                next_state = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Button requests are simply dropped in auto mode or while paused; nothing is queued
    always_comb begin
        step_req     = (state == PRESS_WAIT) && btn_s && (cnt == CNT_LAST);
        pressed_next = (next_state == HELD) || (next_state == REL_WAIT);
        if (bus.Mode) begin
            en_next = !bus.Pause && (div == DIV_LAST);
        end else begin
            en_next = !bus.Pause && step_req;
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            div <= '0;
        end else if (!bus.Mode) begin
            div <= '0;
        end else if (!bus.Pause) begin
            div <= (div == DIV_LAST) ? '0 : div + 1'b1;
        end
    end

    assign bus.En      = en_q;
    assign bus.Pressed = pressed_q;

endmodule

// File: tb/tb_count_enable_gen.sv
// Scoreboard bench for count_enable_gen: a run-length debounce model and an
// active-edge counter predict En/Pressed per clock; a monitor compares them.
module tb_count_enable_gen;

    localparam int D = 4;
    localparam int T = 10;

    typedef struct packed {
        bit en;
        bit pressed;
    } exp_t;

    logic Clk = 1'b0;
    logic Rst;

    count_enable_gen_if bus();

    count_enable_gen #(
        .DEBOUNCE_CYCLES(D),
        .TICK_DIV(T)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus.slave)
    );

    always #5 Clk = ~Clk;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    bit   checking = 1'b0;

    bit   s1m;
    bit   bsm;
    bit   lvl;
    int   run;
    int   active;
    int   pauseCycles;

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        s1m    = 1'b0;
        bsm    = 1'b0;
        lvl    = 1'b0;
        run    = 0;
        active = 0;
    endtask

    // A debounced level flips once D+1 consecutive synchronized samples disagree with it;
    // auto mode pulses on every T-th unpaused edge since auto mode was entered
    task automatic applyStimulus(input bit btn, input bit mode, input bit pause);
        bit samp;
        bit step;
        bit en;
        @(negedge Clk);
        bus.Btn   = btn;
        bus.Mode  = mode;
        bus.Pause = pause;
        samp = bsm;
        bsm  = s1m;
        s1m  = btn;
        step = 1'b0;
        if (samp != lvl) begin
            run++;
            if (run == D + 1) begin
                lvl  = ~lvl;
                run  = 0;
                step = lvl;
            end
        end else begin
            run = 0;
        end
        en = 1'b0;
        if (mode) begin
            if (!pause) begin
                active++;
                en = (active % T == 0);
            end
        end else begin
            active = 0;
            en     = !pause && step;
        end
        expQ.push_back('{en: en, pressed: lvl});
    endtask

    // Asynchronous reset pulse placed mid-cycle, away from both clock edges
    task automatic resetMid(input bit btn);
        @(posedge Clk);
        #2;
        checking = 1'b0;
        #1;
        Rst = 1'b1;
        #1;
        checkOutput("async_rst_En", bus.En, 0);
        checkOutput("async_rst_Pressed", bus.Pressed, 0);
        modelReset();
        Rst = 1'b0;
        applyStimulus(btn, 1'b0, 1'b0);
        checking = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge Clk);
            #1;
            if (checking) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard_empty: got 0 entries expected 1 at %0t", $time);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("En", bus.En, e.en);
                    checkOutput("Pressed", bus.Pressed, e.pressed);
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        bit [5:0] pat;
        bit       rb;
        bit       rm;
        bit       rp;
        int       len;

        Rst       = 1'b1;
        bus.Btn   = 1'b0;
        bus.Mode  = 1'b0;
        bus.Pause = 1'b0;
        modelReset();
        repeat (3) @(posedge Clk);
        #2;
        checkOutput("reset_En", bus.En, 0);
        checkOutput("reset_Pressed", bus.Pressed, 0);
        checkOutput("reset_div", int'(dut.div), 0);
        @(negedge Clk);
        Rst = 1'b0;

        $display("[TB] clean press and release");
        applyStimulus(1'b0, 1'b0, 1'b0);
        checking = 1'b1;
        repeat (20) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] bounce on press and release");
        pat = 6'b101101;
        for (int i = 5; i >= 0; i--) applyStimulus(pat[i], 1'b0, 1'b0);
        repeat (15) applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 5; i >= 0; i--) applyStimulus(~pat[i], 1'b0, 1'b0);
        repeat (15) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] auto mode");
        repeat (100) applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] pause at terminal count");
        while (active % T != T - 1) applyStimulus(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            @(posedge Clk);
            #2;
            checkOutput("pause_div_hold", int'(dut.div), T - 1);
        end
        repeat (15) applyStimulus(1'b0, 1'b1, 1'b0);

        $display("[TB] press during auto mode, then switch to step");
        repeat (20) applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(posedge Clk);
        #2;
        checkOutput("mode_switch_div", int'(dut.div), 0);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] press lost while paused");
        repeat (12) applyStimulus(1'b1, 1'b0, 1'b1);
        repeat (8) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] reset during PRESS_WAIT and during HELD");
        repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);
        resetMid(1'b1);
        repeat (12) applyStimulus(1'b1, 1'b0, 1'b0);
        resetMid(1'b1);
        repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
        repeat (10) applyStimulus(1'b0, 1'b0, 1'b0);

        $display("[TB] randomized traffic");
        rm = 1'b0;
        rp = 1'b0;
        for (int r = 0; r < 200; r++) begin
            rb  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 8);
            if ($urandom_range(0, 9) == 0) rm = ~rm;
            rp = ($urandom_range(0, 5) == 0);
            repeat (len) applyStimulus(rb, rm, rp);
        end

        repeat (12) applyStimulus(1'b0, 1'b0, 1'b0);
        @(posedge Clk);
        #2;
        checking = 1'b0;
        checkOutput("scoreboard_drained", expQ.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
